// File: rtl/arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating multiplexer.
// The payload width default comes from the project-wide DATA_WIDTH define
// and falls back to 32 when no shared types header has set it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package arb_mux_pkg;

    // Largest channel count the arbiter is intended to serve
    localparam int unsigned ARB_MUX_MAX_IN = 32'd16;

    // Index width for a given channel count; a single channel still needs one bit
    function automatic int sel_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin grant generator: picks the first requester at or
// above the pointer, wrapping from the top channel back to channel 0.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic [SEL_W-1:0] win_idx_s;
    logic             win_vld_s;
    int               cand_s;

    // Walk the channels upward from ptr with wrap and keep the first requester
    always_comb begin
        win_idx_s = '0;
        win_vld_s = 1'b0;
        cand_s    = 32'sd0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand_s = int'(ptr) + k;
            if (cand_s >= NUM_IN) begin
                cand_s = cand_s - NUM_IN;
            end else begin
                cand_s = cand_s;
            end
            if (!win_vld_s && req[SEL_W'(cand_s)]) begin
                win_vld_s = 1'b1;
                win_idx_s = SEL_W'(cand_s);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // One-hot grant only when the consumer is able to take the beat
    always_comb begin
        grant = '0;
        if (en && win_vld_s) begin
            grant[win_idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign grant_idx = win_idx_s;
    assign grant_vld = win_vld_s;

endmodule

// File: rtl/arb_mux.sv
// Round-robin N:1 multiplexer with a single registered output stage.
// in_ready is purely combinational from in_valid, ptr and the output
// handshake state; the selected payload is captured in the output register.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_IN     = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]                 in_valid,
    output logic [NUM_IN-1:0]                 in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [sel_width(NUM_IN)-1:0]      out_sel,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int SEL_W = sel_width(NUM_IN);

    logic [SEL_W-1:0]  ptr;
    logic              load_s;
    logic              arb_en_s;
    logic [NUM_IN-1:0] grant_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic              grant_vld_s;

    // The output slot can take a new beat when empty or being drained this edge;
    // nothing is accepted while reset is held so no beat is lost on the floor.
    assign load_s   = ~out_valid | out_ready;
    assign arb_en_s = load_s & rst_n;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .en        (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_vld (grant_vld_s)
    );

    assign in_ready = grant_s;

    // Output register and round-robin pointer; both move only on a handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_s) begin
            if (grant_vld_s) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx_s];
                out_sel   <= grant_idx_s;
                if (grant_idx_s == SEL_W'(NUM_IN - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx_s + SEL_W'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux (3 channels, 32-bit payload): directed
// scenarios followed by randomized traffic against a behavioural model.
module tb_arb_mux;

    localparam int N  = 3;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0][DW-1:0]   in_data;
    logic [N-1:0]           in_valid;
    logic [N-1:0]           in_ready;
    logic [DW-1:0]          out_data;
    logic [1:0]             out_sel;
    logic                   out_valid;
    logic                   out_ready;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    int          m_sel   = 0;
    int          m_ptr   = 0;

    always #5 clk = ~clk;

    arb_mux #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // first valid channel at or after the model pointer, -1 if none
    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N] === 1'b1) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = winner();
        if (rst_n === 1'b1 && (!m_valid || out_ready === 1'b1) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // one clock: check in_ready, advance model at the edge, check registers
    task automatic cycle(input string tag);
        int w;
        #2;
        chk({tag, " in_ready"}, 64'(in_ready), 64'(exp_ready()));
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            m_valid = 1'b0; m_data = 32'h0; m_sel = 0; m_ptr = 0;
        end else if (!m_valid || out_ready === 1'b1) begin
            w = winner();
            if (w >= 0) begin
                m_valid = 1'b1; m_data = in_data[w]; m_sel = w; m_ptr = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, " out_data"},  64'(out_data),  64'(m_data));
        chk({tag, " out_sel"},   64'(out_sel),   64'(m_sel));
        chk({tag, " ptr"},       64'(dut.ptr),   64'(m_ptr));
    endtask

    int exp_seq [5] = '{0, 1, 2, 0, 1};

    initial begin
        rst_n = 1'b0; in_valid = 3'b111; out_ready = 1'b1;
        in_data[0] = $urandom; in_data[1] = $urandom; in_data[2] = $urandom;

        // reset held two cycles with every channel requesting
        cycle("reset0");
        cycle("reset1");
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data",  64'(out_data),  64'd0);
        chk("reset out_sel",   64'(out_sel),   64'd0);

        // single requester on channel 1
        rst_n = 1'b1; in_valid = 3'b010; in_data[1] = 32'hDEADBEEF;
        cycle("single");
        chk("single out_valid", 64'(out_valid), 64'd1);
        chk("single out_data",  64'(out_data),  64'hDEADBEEF);
        chk("single out_sel",   64'(out_sel),   64'd1);
        chk("single ptr",       64'(dut.ptr),   64'd2);

        // round robin with wrap starting from a fresh pointer
        rst_n = 1'b0;
        cycle("rr reset");
        rst_n = 1'b1; in_valid = 3'b111;
        for (int i = 0; i < N; i++) in_data[i] = 32'(i + 32'h10);
        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            chk("rr seq sel",   64'(out_sel),   64'(exp_seq[i]));
            chk("rr seq valid", 64'(out_valid), 64'd1);
            chk("rr seq data",  64'(out_data),  64'(exp_seq[i] + 32'h10));
        end

        // backpressure holding a channel-2 beat
        cycle("bp load");
        chk("bp loaded sel", 64'(out_sel), 64'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle("bp stall");
            chk("bp stall sel",  64'(out_sel),  64'd2);
            chk("bp stall data", 64'(out_data), 64'h12);
            chk("bp stall ptr",  64'(dut.ptr),  64'd0);
        end
        out_ready = 1'b1;
        cycle("bp release");
        chk("bp release sel", 64'(out_sel), 64'd0);

        // idle drain keeps the last index
        in_valid = 3'b000;
        cycle("drain");
        chk("drain out_valid", 64'(out_valid), 64'd0);
        chk("drain out_sel",   64'(out_sel),   64'd0);

        // reset while a beat is stalled
        in_valid = 3'b100;
        cycle("mid load");
        out_ready = 1'b0; rst_n = 1'b0;
        cycle("mid reset");
        chk("mid out_valid", 64'(out_valid), 64'd0);
        chk("mid ptr",       64'(dut.ptr),   64'd0);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 3'b110;
        cycle("mid after");
        chk("mid after sel", 64'(out_sel), 64'd1);

        // randomized traffic, including data changing while not accepted
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            in_valid  = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) in_data[c] = $urandom;
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), payload width per channel.
REQ-002 SHALL have parameter NUM_IN, default 3, number of input channels; legal range 1..16.
REQ-003 SHALL derive localparam SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1; it is not user-overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_data  input  NUM_IN x DATA_WIDTH  per-channel payload.
REQ-007 in_valid  input  NUM_IN  per-channel request valid.
REQ-008 in_ready  output  NUM_IN  per-channel accept; at most one bit high per cycle.
REQ-009 out_data  output  DATA_WIDTH  registered selected payload.
REQ-010 out_sel  output  SEL_W  registered index of the channel that supplied out_data.
REQ-011 out_valid  output  1  out_data/out_sel hold a beat.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 SHALL contain one output register stage (out_data, out_sel, out_valid); latency input handshake -> out_valid = 1 cycle.
REQ-014 SHALL define load = ~out_valid | out_ready; a beat is accepted only when load = 1.
REQ-015 SHALL grant, among channels with in_valid = 1, the first at or after round-robin pointer ptr, searching upward with wrap from NUM_IN-1 to 0.
REQ-016 SHALL drive in_ready[g] = load & in_valid[g] for granted channel g; all other in_ready bits 0; in_ready SHALL depend combinationally on in_valid, ptr, out_valid and out_ready only, never on in_data.
REQ-017 On a handshake on channel g, SHALL register out_data = in_data[g], out_sel = g, out_valid = 1, and set ptr = (g == NUM_IN-1) ? 0 : g+1.
REQ-018 When load = 1 and no in_valid is high, SHALL clear out_valid and leave out_data, out_sel, ptr unchanged.
REQ-019 While out_valid = 1 and out_ready = 0, out_data, out_sel, out_valid and ptr SHALL hold; all in_ready SHALL be 0.
REQ-020 Simultaneous drain and accept (out_valid = 1, out_ready = 1, some in_valid) SHALL replace the beat in the same edge, sustaining one beat per cycle.
REQ-021 ptr SHALL advance only on a handshake, never on idle or stall cycles.
REQ-022 With NUM_IN = 1, ptr SHALL stay 0, out_sel SHALL be 0, and behaviour reduces to a one-entry pipeline register.
REQ-023 Inputs are expected to hold in_valid/in_data until in_ready; the block SHALL NOT rely on it for correctness of its own state.

Reset
REQ-024 On rising clk with rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
REQ-025 During reset cycles all in_ready SHALL be 0; a buffered beat is discarded when reset asserts mid-operation.
REQ-026 First cycle after rst_n rises SHALL arbitrate normally with ptr = 0.

Structure
REQ-027 The DATA_WIDTH default SHALL come from the existing shared types include; no new shared typedefs are required.
REQ-028 Grant generation SHALL be a sub-module rr_arbiter (params NUM_IN, SEL_W; inputs req, ptr, en; outputs grant one-hot, grant_idx, grant_vld); arb_mux owns ptr and the output register.
REQ-029 The block SHALL be fully synthesizable, single clock domain, no latches.

Verification (NUM_IN = 3, DATA_WIDTH = 32)
REQ-030 Reset: rst_n = 0 two cycles with all in_valid = 1 -> in_ready = 000, out_valid = 0, out_data = 0, out_sel = 0.
REQ-031 Single channel: in_valid = 010, in_data[1] = 0xDEADBEEF, out_ready = 1 -> next cycle out_valid = 1, out_data = 0xDEADBEEF, out_sel = 1; ptr = 2.
REQ-032 Round robin with wrap: all in_valid = 1 held, out_ready = 1, data[i] = i+0x10 -> out_sel sequence 0,1,2,0,1 on consecutive cycles, out_valid continuously 1.
REQ-033 Backpressure: out_ready = 0 for 4 cycles with beat out_sel = 2 buffered -> out_data/out_sel stable, in_ready = 000, ptr unchanged; out_ready = 1 -> next beat from channel 0 same edge.
REQ-034 Idle drain: one beat buffered, in_valid = 000, out_ready = 1 -> out_valid = 0 next cycle, out_sel unchanged.
REQ-035 Reset mid-operation: beat buffered with out_ready = 0, rst_n = 0 one cycle -> out_valid = 0, ptr = 0; afterwards in_valid = 110 grants channel 1 first.
